ram_fifo_ctrl: RTL and testbench



---
 rtl/ram_fifo_ctrl.sv | 89 ++++++++
 tb/tb_ram_fifo_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous RAM.
// Arbitrates one RAM operation per cycle between pushes (writes) and
// head refills (reads). Reads win. Read data is captured into an output
// holding register one cycle after the address is issued.
module ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_count;
  logic                  r_rd_pending;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic w_read_issue;
  logic w_push;

  // Refill the head whenever the RAM has data, no read is in flight and
  // the output register is free (or being emptied this cycle).
  assign w_read_issue = (r_ram_count != '0) && !r_rd_pending &&
                        (!r_out_valid || out_ready);

  assign in_ready = !rst && (r_ram_count < LP_DEPTH) && !w_read_issue;
  assign w_push   = in_valid && in_ready;

  // Idle cycles park the address on the read pointer; with we low it is harmless.
  assign ram_we      = w_push;
  assign ram_addr    = w_push ? r_wr_ptr : r_rd_ptr;
  assign ram_data_in = in_data;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign count     = r_ram_count
                   + (ADDR_WIDTH+1)'(r_rd_pending)
                   + (ADDR_WIDTH+1)'(r_out_valid);

  // Pointer and occupancy bookkeeping for the RAM-resident portion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
    end else begin
      if (w_read_issue) begin
        r_rd_ptr    <= r_rd_ptr + ADDR_WIDTH'(1);
        r_ram_count <= r_ram_count - (ADDR_WIDTH+1)'(1);
      end else if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(1);
        r_ram_count <= r_ram_count + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Read-in-flight flag and output holding register; capture beats drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pending <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_rd_pending <= w_read_issue;
      if (r_rd_pending) begin
        r_out_valid <= 1'b1;
        r_out_data  <= ram_data_out;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: RAM model plus a queue-based reference of the
// FIFO contents, with per-scenario tasks doing their own comparisons.
module tb_ram_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [AW:0]   count;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // single-port RAM, registered read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_idx = 0;
  logic [DW-1:0] q[$];

  logic          s_rst, s_push, s_pop, s_in_ready, s_we;
  logic [AW-1:0] s_addr, s_waddr_exp;
  logic [DW-1:0] s_din, s_pop_act, s_pop_exp;

  // Sample the cycle's handshakes, clock once, advance the reference.
  task automatic tick();
    #1;
    s_rst = rst; s_in_ready = in_ready; s_we = ram_we; s_addr = ram_addr;
    s_din = in_data; s_push = in_valid && in_ready;
    s_pop = out_valid && out_ready; s_pop_act = out_data;
    s_pop_exp = 'x; s_waddr_exp = AW'(wr_idx);
    @(posedge clk); #1; cyc++;
    if (s_rst === 1'b1) begin q.delete(); wr_idx = 0; end
    else begin
      if (s_pop === 1'b1 && q.size() > 0) s_pop_exp = q.pop_front();
      if (s_push === 1'b1) begin q.push_back(s_din); wr_idx++; end
    end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_data = 4'h7; out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (s_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", s_in_ready); end
      total++; if (s_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b exp=0", s_we); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    end
    rst = 0; in_data = 4'h3;
    tick();
    total++; if (s_we !== 1'b1 || s_addr !== 4'd0) begin bad++; $display("FAIL reset_first_write we=%b addr=%0d exp we=1 addr=0", s_we, s_addr); end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_pop === 1'b1) begin
        total++; if (s_pop_act !== 4'h3) begin bad++; $display("FAIL reset_first_data got=%h exp=3", s_pop_act); end
      end
    end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_single();
    logic [AW-1:0] wa;
    wa = AW'(wr_idx);
    in_valid = 1; in_data = 4'hA; out_ready = 1;
    tick();
    total++; if (s_we !== 1'b1 || s_addr !== wa || s_push !== 1'b1) begin bad++; $display("FAIL single_write we=%b addr=%0d exp addr=%0d", s_we, s_addr, wa); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", count); end
    in_valid = 0;
    tick();
    total++; if (s_we !== 1'b0 || s_addr !== wa) begin bad++; $display("FAIL single_read we=%b addr=%0d exp we=0 addr=%0d", s_we, s_addr, wa); end
    total++; if (count !== 5'd1 || out_valid !== 1'b0) begin bad++; $display("FAIL single_count2 count=%0d ov=%b exp 1,0", count, out_valid); end
    tick();
    total++; if (count !== 5'd1 || out_valid !== 1'b1 || out_data !== 4'hA) begin bad++; $display("FAIL single_capture count=%0d ov=%b data=%h exp 1,1,a", count, out_valid, out_data); end
    tick();
    total++; if (s_pop !== 1'b1 || s_pop_act !== s_pop_exp) begin bad++; $display("FAIL single_pop pop=%b data=%h exp=%h", s_pop, s_pop_act, s_pop_exp); end
    total++; if (count !== 5'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_empty count=%0d ov=%b exp 0,0", count, out_valid); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] vals [17];
    int idx;
    for (int i = 0; i < 16; i++) vals[i] = DW'(i);
    vals[16] = 4'h1;
    idx = 0; out_ready = 0;
    for (int i = 0; i < 200 && idx < 17; i++) begin
      in_valid = 1; in_data = vals[idx];
      tick();
      if (s_push === 1'b1) idx++;
    end
    total++; if (idx != 17) begin bad++; $display("FAIL fill_accepted got=%0d exp=17", idx); end
    total++; if (count !== 5'd17) begin bad++; $display("FAIL fill_count got=%0d exp=17", count); end
    in_data = 4'h9;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (s_in_ready !== 1'b0 || s_push !== 1'b0) begin bad++; $display("FAIL fill_hold in_ready=%b exp=0", s_in_ready); end
    end
    total++; if (count !== 5'd17) begin bad++; $display("FAIL fill_count_hold got=%0d exp=17", count); end
    in_valid = 0;
  endtask

  task automatic test_drain();
    int last, npop;
    last = -1; npop = 0; out_ready = 1; in_valid = 0;
    for (int i = 0; i < 80 && (q.size() > 0 || out_valid === 1'b1); i++) begin
      tick();
      if (s_pop === 1'b1) begin
        total++; if (s_pop_act !== s_pop_exp) begin bad++; $display("FAIL drain_data got=%h exp=%h", s_pop_act, s_pop_exp); end
        if (last >= 0) begin
          total++; if (cyc - last != 2) begin bad++; $display("FAIL drain_spacing got=%0d exp=2", cyc - last); end
        end
        last = cyc; npop++;
      end
    end
    total++; if (npop != 17) begin bad++; $display("FAIL drain_npop got=%0d exp=17", npop); end
    total++; if (count !== 5'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty count=%0d ov=%b exp 0,0", count, out_valid); end
  endtask

  // drain leftover items, checking order
  task automatic drain_checked(input string tag);
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 80 && (q.size() > 0 || out_valid === 1'b1); i++) begin
      tick();
      if (s_pop === 1'b1) begin
        total++; if (s_pop_act !== s_pop_exp) begin bad++; $display("FAIL %s_drain_data got=%h exp=%h", tag, s_pop_act, s_pop_exp); end
      end
    end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL %s_drain_count got=%0d exp=0", tag, count); end
  endtask

  task automatic test_contention();
    bit prev_low;
    int nlow, nacc;
    prev_low = 0; nlow = 0; nacc = 0;
    in_valid = 1; out_ready = 1; in_data = DW'($urandom);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (s_pop === 1'b1) begin
        total++; if (s_pop_act !== s_pop_exp) begin bad++; $display("FAIL cont_data got=%h exp=%h", s_pop_act, s_pop_exp); end
      end
      total++; if (count !== 5'(q.size())) begin bad++; $display("FAIL cont_count got=%0d exp=%0d", count, q.size()); end
      total++; if (s_in_ready !== 1'b1 && prev_low) begin bad++; $display("FAIL cont_ready_low_twice got=%b exp=1", s_in_ready); end
      prev_low = (s_in_ready !== 1'b1);
      if (prev_low) nlow++;
      if (s_push === 1'b1) begin
        nacc++;
        total++; if (s_addr !== s_waddr_exp) begin bad++; $display("FAIL cont_waddr got=%0d exp=%0d", s_addr, s_waddr_exp); end
        in_data = DW'($urandom);
      end
    end
    total++; if (nlow == 0 || nacc < 30) begin bad++; $display("FAIL cont_mix low=%0d acc=%0d exp low>0 acc>=30", nlow, nacc); end
    drain_checked("cont");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); in_data = DW'($urandom);
      tick();
      if (s_pop === 1'b1) begin
        total++; if (s_pop_act !== s_pop_exp) begin bad++; $display("FAIL rand_data got=%h exp=%h", s_pop_act, s_pop_exp); end
      end
      if (s_push === 1'b1) begin
        total++; if (s_addr !== s_waddr_exp) begin bad++; $display("FAIL rand_waddr got=%0d exp=%0d", s_addr, s_waddr_exp); end
      end
      total++; if (count !== 5'(q.size())) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", count, q.size()); end
    end
    drain_checked("rand");
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    in_valid = 1; in_data = 4'hC; out_ready = 0;
    tick();
    in_valid = 0;
    tick();
    total++; if (s_we !== 1'b0 || count !== 5'd1) begin bad++; $display("FAIL rmr_issue we=%b count=%0d exp 0,1", s_we, count); end
    rst = 1;
    tick();
    rst = 0;
    total++; if (out_valid !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL rmr_cleared ov=%b count=%0d exp 0,0", out_valid, count); end
    repeat (3) tick();
    total++; if (out_valid !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL rmr_idle ov=%b count=%0d exp 0,0", out_valid, count); end
    in_valid = 1; in_data = 4'h5; out_ready = 1;
    tick();
    in_valid = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (s_pop === 1'b1) begin
        seen = 1;
        total++; if (s_pop_act !== 4'h5 || s_pop_exp !== 4'h5) begin bad++; $display("FAIL rmr_first got=%h exp=5", s_pop_act); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL rmr_timeout got=no_output exp=output"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_contention();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
